indicator_input_cond: RTL and testbench
=======================================

Name: indicator_input_cond

Overview:
Input conditioner that sits directly upstream of the LED indicator logic in PowerGear V2. It receives six raw asynchronous status pins: battery level, user button, USB present, charger STAT, and the pos/neg current-sense comparators. Each pin is synchronised and debounced into a clean level. The button additionally drives a timed "show" window, so the LEDs stay lit for a fixed time after a press.
All outputs are registered and feed the indicator inputs directly (level, button, usb, stat, pos, neg).

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per input (min 2)
DEB_W, 16, width of each debounce counter
DEB_CYCLES, 10000, consecutive mismatching samples required before a clean output toggles (1..2^DEB_W-1)
SHOW_W, 24, width of the show-window counter
SHOW_CYCLES, 3000000, cycles the button output stays high after debounced release (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
level_in  in  1  raw battery-level comparator
button_in  in  1  raw push-button, active-high
usb_in  in  1  raw USB VBUS detect
stat_in  in  1  raw charger STAT pin
pos_in  in  1  raw positive-current comparator
neg_in  in  1  raw negative-current comparator
level  out  1  debounced level
button  out  1  show-window output: high while pressed plus SHOW_CYCLES after release
usb  out  1  debounced usb
stat  out  1  debounced stat
pos  out  1  debounced pos
neg  out  1  debounced neg
btn_pulse  out  1  one-cycle pulse on each debounced button press

Behaviour:
- Reset, rst=0 (asynchronous): all sync flops, debounce counters and clean levels clear to 0. The show counter clears to 0, the FSM returns to IDLE, and every output is 0. Release takes effect on the next clk edge.
- Reset asserted mid-operation (during a debounce count or a SHOW window) clears everything immediately. No pending toggle or window survives reset.
- Synchroniser: each raw input passes through SYNC_STAGES flops.
- Debounce, per channel:
  - If the synced value differs from the clean value, cnt increments.
  - If they are equal, cnt clears to 0.
  - When a mismatch is seen with cnt == DEB_CYCLES-1, the clean value toggles and cnt clears to 0 on the same edge.
  - Any single matching sample restarts the count, so glitches shorter than DEB_CYCLES cycles never propagate.
- Latency: a clean level changes on the (SYNC_STAGES+DEB_CYCLES)-th rising edge. The first edge that samples the new raw value counts as edge 1. This latency is identical for rising and falling transitions.
- Counter arithmetic: the counter never exceeds DEB_CYCLES-1, so no wrap is possible.
- btn_pulse: high for exactly one cycle, on the cycle after the debounced button goes 0->1. It never fires on release.
- Button FSM (db_btn = debounced button):
  - IDLE: button=0. db_btn rising -> PRESS.
  - PRESS: button=1; show counter held at SHOW_CYCLES. db_btn falling -> SHOW.
  - SHOW: button=1; counter decrements by 1 each cycle.
    - db_btn rising -> PRESS (retrigger reloads the window).
    - Counter reaches 1 with no press -> IDLE; button is 0 on the following cycle.
  - Window length: button stays high for exactly SHOW_CYCLES cycles after the cycle in which db_btn falls.
  - Simultaneous press and expiry in the same cycle: the press wins and the FSM goes to PRESS.
  - Illegal state encoding -> IDLE.
- The other five channels are plain debounced levels with no edge logic.

Decomposition:
- Shared include file:
  - FSM state encodings: IDLE=2'd0, PRESS=2'd1, SHOW=2'd2.
  - Reset values.
- Sub-module: indicator_debounce (synchroniser plus debounce counter for one bit, parameters SYNC_STAGES/DEB_W/DEB_CYCLES), instantiated six times.
- The top level holds the button FSM, the show counter and the btn_pulse edge detect.

Test Plan:
All scenarios use sim overrides SYNC_STAGES=2, DEB_CYCLES=4, SHOW_CYCLES=20.
1. Hold rst=0 with all raw inputs at 1 -> all outputs 0. Release rst -> outputs stay 0 for 5 edges, then all debounced levels rise on edge 6.
2. usb_in high for 3 cycles then low -> usb never rises and btn_pulse stays 0.
3. stat_in 0->1 held -> stat rises on edge 6. stat_in 1->0 held -> stat falls on edge 6.
4. button_in high for 10 cycles then low -> btn_pulse is a single 1-cycle pulse; button rises with the debounced press, stays high through the debounced release, then holds exactly 20 more cycles before falling to 0.
5. Second press 8 cycles into the SHOW window -> second btn_pulse fires, FSM goes to PRESS, and the window restarts at 20 after the new release.
6. rst pulsed low for 1 cycle mid-SHOW -> button and all levels drop to 0 asynchronously. After release, stable inputs re-appear after 6 edges and button stays 0.

Source files
------------

// File: rtl/indicator_input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : indicator_input_cond_pkg
// Description : Shared types and constants for the indicator input
//               conditioner: button FSM encoding, reset values and the
//               channel index map used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package indicator_input_cond_pkg;

   // Button show-window FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      SHOW  = 2'd2
   } btn_state_t;

   // Value taken by every sync flop, clean level and output under reset
   localparam logic       RST_LEVEL = 1'b0;
   localparam btn_state_t RST_STATE = IDLE;

   // Channel map for the six conditioned status inputs
   localparam int NUM_CH   = 6;
   localparam int CH_LEVEL = 0;
   localparam int CH_BTN   = 1;
   localparam int CH_USB   = 2;
   localparam int CH_STAT  = 3;
   localparam int CH_POS   = 4;
   localparam int CH_NEG   = 5;

endpackage : indicator_input_cond_pkg
`default_nettype wire

// File: rtl/indicator_debounce.sv
`default_nettype none
// ============================================================================
// Module      : indicator_debounce
// Description : One-bit synchroniser followed by a mismatch-count debouncer.
//               The clean level toggles only after DEB_CYCLES consecutive
//               synced samples disagree with it; any agreeing sample restarts
//               the count.
// Revision    : 1.0 - initial release
// ============================================================================
import indicator_input_cond_pkg::*;

module indicator_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16,
   parameter int DEB_CYCLES  = 10000
) (
   input  logic clk,
   input  logic rst,      // asynchronous, active-low
   input  logic raw,
   output logic clean
);

   // Terminal count: a mismatch seen at this value flips the clean level
   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [DEB_W-1:0]       cnt;

   // Shift the raw pin through the synchroniser chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {SYNC_STAGES{RST_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Count consecutive disagreeing samples; the count never passes CNT_LAST
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         clean <= RST_LEVEL;
      end else if (synced == clean) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         clean <= ~clean;
         cnt   <= '0;
      end else begin
         cnt <= cnt + DEB_W'(1);
      end
   end

endmodule : indicator_debounce
`default_nettype wire

// File: rtl/indicator_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : indicator_input_cond
// Description : Conditions the six raw status pins feeding the LED indicator
//               logic. Every pin is synchronised and debounced; the button
//               additionally drives a show window that keeps the button
//               output high for SHOW_CYCLES cycles after release, and a
//               one-cycle pulse on each debounced press.
// Revision    : 1.0 - initial release
// ============================================================================
import indicator_input_cond_pkg::*;

module indicator_input_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 16,
   parameter int DEB_CYCLES  = 10000,
   parameter int SHOW_W      = 24,
   parameter int SHOW_CYCLES = 3000000
) (
   input  logic clk,
   input  logic rst,          // asynchronous, active-low
   input  logic level_in,
   input  logic button_in,
   input  logic usb_in,
   input  logic stat_in,
   input  logic pos_in,
   input  logic neg_in,
   output logic level,
   output logic button,
   output logic usb,
   output logic stat,
   output logic pos,
   output logic neg,
   output logic btn_pulse
);

   localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYCLES);
   localparam logic [SHOW_W-1:0] SHOW_ONE  = SHOW_W'(1);

   logic [NUM_CH-1:0] raw_vec;
   logic [NUM_CH-1:0] clean_vec;
   logic              db_btn;
   logic              db_btn_d;
   btn_state_t        state;
   logic [SHOW_W-1:0] show_cnt;

   assign raw_vec[CH_LEVEL] = level_in;
   assign raw_vec[CH_BTN]   = button_in;
   assign raw_vec[CH_USB]   = usb_in;
   assign raw_vec[CH_STAT]  = stat_in;
   assign raw_vec[CH_POS]   = pos_in;
   assign raw_vec[CH_NEG]   = neg_in;

   // One synchroniser + debouncer per raw pin
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      indicator_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_W       (DEB_W),
         .DEB_CYCLES  (DEB_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_vec[ch]),
         .clean (clean_vec[ch])
      );
   end

   // The debouncer outputs are registers, so the level outputs are too
   assign level  = clean_vec[CH_LEVEL];
   assign usb    = clean_vec[CH_USB];
   assign stat   = clean_vec[CH_STAT];
   assign pos    = clean_vec[CH_POS];
   assign neg    = clean_vec[CH_NEG];
   assign db_btn = clean_vec[CH_BTN];

   // Rising-edge detect on the debounced button; release never pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_btn_d  <= RST_LEVEL;
         btn_pulse <= RST_LEVEL;
      end else begin
         db_btn_d  <= db_btn;
         btn_pulse <= db_btn & ~db_btn_d;
      end
   end

   // Show-window FSM: press holds the window loaded, release lets it drain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RST_STATE;
         show_cnt <= '0;
         button   <= RST_LEVEL;
      end else begin
         case (state)
            IDLE: begin
               if (db_btn) begin
                  state    <= PRESS;
                  show_cnt <= SHOW_LOAD;
                  button   <= 1'b1;
               end else begin
                  show_cnt <= '0;
                  button   <= 1'b0;
               end
            end
            PRESS: begin
               // Window stays full while the button is held
               show_cnt <= SHOW_LOAD;
               button   <= 1'b1;
               if (!db_btn) begin
                  state <= SHOW;
               end
            end
            SHOW: begin
               // A new press outranks an expiring window in the same cycle
               if (db_btn) begin
                  state    <= PRESS;
                  show_cnt <= SHOW_LOAD;
                  button   <= 1'b1;
               end else if (show_cnt <= SHOW_ONE) begin
                  state    <= IDLE;
                  show_cnt <= '0;
                  button   <= 1'b0;
               end else begin
                  show_cnt <= show_cnt - SHOW_ONE;
                  button   <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               show_cnt <= '0;
               button   <= 1'b0;
            end
         endcase
      end
   end

endmodule : indicator_input_cond
`default_nettype wire

// File: tb/tb_indicator_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_indicator_input_cond
// Description : Self-checking bench for indicator_input_cond with
//               SYNC_STAGES=2, DEB_CYCLES=4, SHOW_CYCLES=20. Each scenario
//               queues the expected output vector for every upcoming edge
//               and pops/compares one entry per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_indicator_input_cond;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic level_in = 1'b0, button_in = 1'b0, usb_in = 1'b0;
   logic stat_in = 1'b0, pos_in = 1'b0, neg_in = 1'b0;
   logic level, button, usb, stat, pos, neg, btn_pulse;
   logic [6:0] obs;
   logic [6:0] exp_v;
   logic [6:0] sb[$];
   int checks = 0;
   int errors = 0;

   indicator_input_cond #(
      .SYNC_STAGES (2),
      .DEB_W       (16),
      .DEB_CYCLES  (4),
      .SHOW_W      (24),
      .SHOW_CYCLES (20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .level_in  (level_in),
      .button_in (button_in),
      .usb_in    (usb_in),
      .stat_in   (stat_in),
      .pos_in    (pos_in),
      .neg_in    (neg_in),
      .level     (level),
      .button    (button),
      .usb       (usb),
      .stat      (stat),
      .pos       (pos),
      .neg       (neg),
      .btn_pulse (btn_pulse)
   );

   always #5 clk = ~clk;

   assign obs = {level, button, usb, stat, pos, neg, btn_pulse};

   // Expected vector in obs order
   function automatic logic [6:0] ev(input logic lv, input logic bt, input logic us,
                                     input logic st, input logic ps, input logic ng,
                                     input logic pl);
      return {lv, bt, us, st, ps, ng, pl};
   endfunction

   task automatic drive_raw(input logic lv, input logic bt, input logic us,
                            input logic st, input logic ps, input logic ng);
      level_in = lv; button_in = bt; usb_in = us;
      stat_in = st; pos_in = ps; neg_in = ng;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive_raw(1, 1, 1, 1, 1, 1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", obs, 7'b0);
      end
      @(negedge clk) rst = 1'b1;
      // All inputs high: levels at edge 6, button and pulse one edge later
      for (int k = 1; k <= 8; k++) begin
         if (k < 6)       sb.push_back(7'b0);
         else if (k == 6) sb.push_back(ev(1, 0, 1, 1, 1, 1, 0));
         else if (k == 7) sb.push_back(ev(1, 1, 1, 1, 1, 1, 1));
         else             sb.push_back(ev(1, 1, 1, 1, 1, 1, 0));
      end
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
      // All inputs low: levels fall at edge 6, button holds 20 more cycles
      drive_raw(0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 30; k++) begin
         sb.push_back(ev(k < 6, k < 27, k < 6, k < 6, k < 6, k < 6, 0));
      end
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_fall edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_glitch();
      for (int k = 1; k <= 12; k++) sb.push_back(7'b0);
      for (int k = 1; k <= 12; k++) begin
         usb_in   = (k <= 3);
         level_in = (k == 2);
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL glitch edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_deb_boundary();
      // A pulse exactly DEB_CYCLES long does get through
      for (int k = 1; k <= 14; k++) sb.push_back(ev(0, 0, 0, 0, 0, (k >= 6 && k <= 9), 0));
      for (int k = 1; k <= 14; k++) begin
         neg_in = (k <= 4);
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL deb_boundary edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_stat_edges();
      stat_in = 1'b1;
      for (int k = 1; k <= 8; k++) sb.push_back(ev(0, 0, 0, k >= 6, 0, 0, 0));
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL stat_rise edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
      stat_in = 1'b0;
      for (int k = 1; k <= 8; k++) sb.push_back(ev(0, 0, 0, k < 6, 0, 0, 0));
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL stat_fall edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_show_window();
      // Press edges 1..10: db rises 6, falls 16; button 7..36, pulse at 7
      for (int k = 1; k <= 45; k++) sb.push_back(ev(0, (k >= 7 && k <= 36), 0, 0, 0, 0, k == 7));
      for (int k = 1; k <= 45; k++) begin
         button_in = (k <= 10);
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL show_window edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_retrigger();
      // Second press 20..29 lands mid-window: db rises 25, falls 35
      for (int k = 1; k <= 60; k++)
         sb.push_back(ev(0, (k >= 7 && k <= 55), 0, 0, 0, 0, (k == 7 || k == 26)));
      for (int k = 1; k <= 60; k++) begin
         button_in = (k <= 10) || (k >= 20 && k <= 29);
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL retrigger edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 1; k <= 25; k++)
         sb.push_back(ev(k >= 6, k >= 7, k >= 6, k >= 6, k >= 6, k >= 6, k == 7));
      for (int k = 1; k <= 25; k++) begin
         drive_raw(1, (k <= 10), 1, 1, 1, 1);
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_pre edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
      // Window is active here; reset must clear it without a clock edge
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL reset_mid_async: got %b expected %b", obs, 7'b0);
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL reset_mid_held: got %b expected %b", obs, 7'b0);
      end
      @(negedge clk) rst = 1'b1;
      for (int k = 1; k <= 20; k++) sb.push_back(ev(k >= 6, 0, k >= 6, k >= 6, k >= 6, k >= 6, 0));
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_post edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
      drive_raw(0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 10; k++) sb.push_back(ev(k < 6, 0, k < 6, k < 6, k < 6, k < 6, 0));
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_idle edge %0d: got %b expected %b", k, obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_deb_boundary();
      test_stat_edges();
      test_show_window();
      test_retrigger();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_indicator_input_cond
`default_nettype wire
